// File: rtl/keypad_alu.sv
// Keypad-driven calculator: scans a 4x4 active-low matrix, debounces presses by
// edge-detecting the scanned key vector, and runs a small integer ALU FSM on the keys.
module keypad_alu #(
  parameter int N        = 8,
  parameter int SCAN_DIV = 300_000
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [3:0]     row,
  output logic [3:0]     col,
  output logic [2*N-1:0] q,
  output logic [3:0]     key_code,
  output logic           key_valid,
  output logic [2:0]     state
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ADD     = 3'd1,
    SUB     = 3'd2,
    MUL     = 3'd3,
    DIV     = 3'd4,
    EQUALS  = 3'd6
  } st_t;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      keys_p0;
  logic [15:0]      keys_p1;
  logic             press_p0;
  logic [N-1:0]     opa;
  logic [N-1:0]     opb;
  st_t              st;

  function automatic logic [3:0] enc(input logic [15:0] k);
    enc = 4'd0;
    for (int i = 0; i < 16; i++)
      if (k[i]) enc = 4'(i);
  endfunction

  // Decimal entry; a digit that would overflow N bits leaves the operand untouched.
  function automatic logic [N-1:0] acc_digit(input logic [N-1:0] cur, input logic [3:0] d);
    logic [N+3:0] t;
    t = ({4'b0, cur} << 3) + ({4'b0, cur} << 1) + {{N{1'b0}}, d};
    acc_digit = (t[N+3:N] != 4'd0) ? cur : t[N-1:0];
  endfunction

  function automatic logic [2*N-1:0] sat_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    sat_sub = (a < b) ? '1 : {{N{1'b0}}, a - b};
  endfunction

  function automatic logic [2*N-1:0] sat_div(input logic [N-1:0] a, input logic [N-1:0] b);
    sat_div = (b == '0) ? '1 : {{N{1'b0}}, a / b};
  endfunction

  function automatic logic [2*N-1:0] alu(input st_t op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      ADD:     alu = {{N{1'b0}}, a} + {{N{1'b0}}, b};
      SUB:     alu = sat_sub(a, b);
      MUL:     alu = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      DIV:     alu = sat_div(a, b);
      default: alu = {{N{1'b0}}, a};
    endcase
  endfunction

  assign col      = ~(4'b0001 << col_idx);
  assign state    = st;
  assign press_p0 = (keys_p0 != 16'd0) && (keys_p1 == 16'd0);

  // Stage 0: column scan and key-vector latch; stage 1: press edge detect
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_cnt  <= '0;
      col_idx   <= 2'd0;
      keys_p0   <= 16'd0;
      keys_p1   <= 16'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      if (scan_cnt == CNT_LAST) begin
        scan_cnt                       <= '0;
        col_idx                        <= col_idx + 2'd1;
        keys_p0[{col_idx, 2'b00} +: 4] <= ~row;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      keys_p1   <= keys_p0;
      key_valid <= press_p0;
      if (press_p0) key_code <= enc(keys_p0);
    end
  end

  // Stage 2: calculator FSM consumes accepted keys
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st  <= ENTER_A;
      opa <= '0;
      opb <= '0;
      q   <= '0;
    end else begin
      case (st)
        ENTER_A: begin
          if (key_valid) begin
            if (key_code <= 4'd9) opa <= acc_digit(opa, key_code);
            else begin
              case (key_code)
                4'hA: st <= ADD;
                4'hB: st <= SUB;
                4'hC: st <= MUL;
                4'hD: st <= DIV;
                4'hF: begin
                  q  <= {{N{1'b0}}, opa};
                  st <= EQUALS;
                end
                default: ;
              endcase
            end
          end
        end
        ADD, SUB, MUL, DIV: begin
          if (key_valid) begin
            if (key_code <= 4'd9) opb <= acc_digit(opb, key_code);
            else if (key_code == 4'hF) begin
              q  <= alu(st, opa, opb);
              st <= EQUALS;
            end
          end
        end
        EQUALS: ;
        default: st <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_alu.sv
// Bench for keypad_alu: keypad matrix model, key-code scoreboard and table of calculations.
module tb_keypad_alu;
  localparam int N        = 8;
  localparam int SCAN_DIV = 4;
  localparam int ROUND    = 4 * SCAN_DIV;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic [3:0]     row;
  logic [3:0]     col;
  logic [2*N-1:0] q;
  logic [3:0]     key_code;
  logic           key_valid;
  logic [2:0]     state;

  logic [15:0] pressed = 16'd0;
  logic [3:0]  exp_codes[$];
  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  keypad_alu #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .clr(clr), .row(row), .col(col), .q(q),
    .key_code(key_code), .key_valid(key_valid), .state(state)
  );

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (pressed[4*c+r]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted press must match the next queued key code.
  always @(negedge clk) begin
    if (!clr && key_valid) begin
      pulses++;
      if (exp_codes.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_key_valid: got code %0h expected none", key_code);
      end else begin
        check("key_code", {28'd0, key_code}, {28'd0, exp_codes.pop_front()});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic [3:0] k);
    exp_codes.push_back(k);
    pressed[k] = 1'b1;
    wait_cyc(2 * ROUND);
    pressed[k] = 1'b0;
    wait_cyc(2 * ROUND);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr     = 1'b1;
    pressed = 16'd0;
    wait_cyc(2);
    exp_codes.delete();
    pulses = 0;
    clr    = 1'b0;
  endtask

  typedef struct {
    int          nk;
    logic [47:0] seq;
    logic [15:0] exp_q;
    logic [2:0]  exp_st;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{5, 48'h12A3F0000000, 16'd15,    3'd6, 8'd12,  8'd3};
    vecs[1] = '{4, 48'h5B9F00000000, 16'hFFFF,  3'd6, 8'd5,   8'd9};
    vecs[2] = '{4, 48'h9B5F00000000, 16'd4,     3'd6, 8'd9,   8'd5};
    vecs[3] = '{9, 48'h2552C255F000, 16'd65025, 3'd6, 8'd255, 8'd255};
    vecs[4] = '{3, 48'h7DF000000000, 16'hFFFF,  3'd6, 8'd7,   8'd0};
    vecs[5] = '{6, 48'h100D7F000000, 16'd14,    3'd6, 8'd100, 8'd7};
    vecs[6] = '{3, 48'h42F000000000, 16'd42,    3'd6, 8'd42,  8'd0};
    vecs[7] = '{6, 48'h3AEC4F000000, 16'd7,     3'd6, 8'd3,   8'd4};
    vecs[8] = '{8, 48'h200A100F0000, 16'd300,   3'd6, 8'd200, 8'd100};
    vecs[9] = '{5, 48'h6F7AF0000000, 16'd6,     3'd6, 8'd6,   8'd0};

    wait_cyc(3);
    check("rst_q", {16'd0, q}, 32'd0);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_keys", {16'd0, dut.keys_p0}, 32'd0);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].nk; i++) begin
        logic [47:0] s;
        s = vecs[v].seq;
        tap(s[47-4*i -: 4]);
      end
      check($sformatf("v%0d_q", v), {16'd0, q}, {16'd0, vecs[v].exp_q});
      check($sformatf("v%0d_state", v), {29'd0, state}, {29'd0, vecs[v].exp_st});
      check($sformatf("v%0d_a", v), {24'd0, dut.opa}, {24'd0, vecs[v].exp_a});
      check($sformatf("v%0d_b", v), {24'd0, dut.opb}, {24'd0, vecs[v].exp_b});
      check($sformatf("v%0d_pulses", v), pulses, vecs[v].nk);
    end

    // Held key: one acceptance over many scan rounds
    do_reset();
    exp_codes.push_back(4'd4);
    pressed[4] = 1'b1;
    wait_cyc(10 * ROUND);
    check("hold_pulses", pulses, 1);
    check("hold_a", {24'd0, dut.opa}, 32'd4);
    pressed = 16'd0;
    wait_cyc(2 * ROUND);
    check("hold_release_pulses", pulses, 1);

    // Simultaneous 3 and 9 pressed while column 1 is driven: column 2 latches first
    do_reset();
    exp_codes.push_back(4'd9);
    begin
      int n;
      n = 0;
      while (col !== 4'b1101 && n < 2 * ROUND) begin
        wait_cyc(1);
        n++;
      end
      check("sim_col_found", {31'd0, col === 4'b1101}, 32'd1);
    end
    pressed[3] = 1'b1;
    pressed[9] = 1'b1;
    wait_cyc(3 * ROUND);
    check("sim_key_code", {28'd0, key_code}, 32'd9);
    check("sim_pulses", pulses, 1);
    check("sim_a", {24'd0, dut.opa}, 32'd9);
    pressed = 16'd0;
    wait_cyc(2 * ROUND);

    // Asynchronous clear in MUL mid column dwell
    do_reset();
    tap(4'd3);
    tap(4'hC);
    tap(4'd6);
    check("mul_state", {29'd0, state}, 32'd3);
    check("mul_b", {24'd0, dut.opb}, 32'd6);
    begin
      int n;
      n = 0;
      while (col !== 4'b1011 && n < 2 * ROUND) begin
        wait_cyc(1);
        n++;
      end
    end
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("async_q", {16'd0, q}, 32'd0);
    check("async_state", {29'd0, state}, 32'd0);
    check("async_col", {28'd0, col}, 32'hE);
    check("async_b", {24'd0, dut.opb}, 32'd0);
    wait_cyc(2);
    clr = 1'b0;
    wait_cyc(2);
    check("exp_queue_empty", exp_codes.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_alu.md
KEYPAD_ALU -- requirements
Module: keypad_alu

Interface
REQ-001 Parameter N, default 8: operand width in bits.
REQ-002 Parameter SCAN_DIV, default 300_000: clk cycles each keypad column is driven.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, asynchronous and active-high.
REQ-005 row  input  4  keypad row sense, active-low (external pull-ups; pressed key in the driven column reads 0).
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at a time.
REQ-007 q  output  2N  calculation result.
REQ-008 key_code  output  4  code of the most recently accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when a key press is accepted.
REQ-010 state  output  3  current FSM state encoding (ENTER_A=0, ADD=1, SUB=2, MUL=3, DIV=4, EQUALS=6).

Function
REQ-011 Scanner SHALL drive col low in the order col[0], col[1], col[2], col[3], then wrap, holding each for SCAN_DIV cycles.
REQ-012 On the last cycle of each column dwell, the scanner SHALL latch the 4 inverted row bits into keys[4*c+3:4*c], where c is the driven column; keys is a 16-bit internal vector.
REQ-013 Key index SHALL equal 4*column + row number; a bit set in keys means that key is pressed.
REQ-014 The encoder SHALL output the index of the highest set bit of keys, or 0 when no bit is set.
REQ-015 A key press SHALL be accepted only on the transition of keys from all-zero to non-zero; a held key SHALL yield exactly one accepted press.
REQ-016 On acceptance: key_code <= encoder output; key_valid pulses high for exactly one cycle.
REQ-017 Key codes: 0-9 digits; 0xA add; 0xB subtract; 0xC multiply; 0xD divide; 0xE reserved (ignored); 0xF equals.
REQ-018 Internal registers: operands A and B, N bits each, unsigned.
REQ-019 ENTER_A, digit d: A <= A*10 + d, unless the result exceeds 2^N-1, in which case A is unchanged.
REQ-020 ENTER_A, operator key 0xA/0xB/0xC/0xD: go to ADD/SUB/MUL/DIV respectively.
REQ-021 ENTER_A, 0xF: q <= zero-extended A; go to EQUALS.
REQ-022 ADD/SUB/MUL/DIV, digit d: B <= B*10 + d, with the same overflow rule as A; stay in the current state.
REQ-023 ADD/SUB/MUL/DIV, operator key or 0xE: ignored; stay in the current state.
REQ-024 0xF in ADD: q <= A+B, computed at 2N bits, so it never saturates.
REQ-025 0xF in SUB: q <= A-B; if A<B, q <= all ones.
REQ-026 0xF in MUL: q <= A*B, which fits exactly in 2N bits.
REQ-027 0xF in DIV: q <= floor(A/B); if B=0, q <= all ones.
REQ-028 After each 0xF result, the FSM SHALL go to EQUALS.
REQ-029 EQUALS SHALL hold q and ignore all keys until clr.
REQ-030 Unused state encodings SHALL go to ENTER_A on the next cycle.
REQ-031 q changes only on reset or on an accepted 0xF; latency from acceptance to q update is 1 cycle.
REQ-032 Simultaneous keys: REQ-014 priority applies; no further press is accepted until keys return to all-zero.

Reset
REQ-033 While clr=1, regardless of clk: q=0, A=0, B=0, state=ENTER_A, key_code=0, key_valid=0, keys=0, col=4'b1110, scan counter=0.
REQ-034 clr asserted mid-operation (any state, mid-scan) SHALL abort immediately; after clr falls, operation restarts from the reset values.

Verification (bench uses SCAN_DIV=4 and a keypad model that drives row low for a pressed key whenever its column is low)
REQ-035 Press 1, 2, release, 0xA, 3, 0xF -> key_valid pulses 5 times; A=12, B=3; q=15; state=EQUALS.
REQ-036 Enter 5, 0xB, 9, 0xF -> q=16'hFFFF; enter 9, 0xB, 5, 0xF -> q=4.
REQ-037 Enter 255, 0xC, 255, 0xF -> q=65025; a further digit 2 typed while A=255 (before any operator) leaves A=255.
REQ-038 Enter 7, 0xD, 0xF -> q=16'hFFFF; enter 100, 0xD, 7, 0xF -> q=14.
REQ-039 Hold key 4 for 10 scan rounds -> exactly one key_valid and A=4; pressing keys 3 and 9 together -> key_code=9.
REQ-040 Assert clr in MUL with B=6 mid column dwell -> q=0, state=ENTER_A, col=4'b1110 within the same cycle, asynchronously.
